// File: rtl/sram_pkg.sv
// Shared types and lane helpers for the byte-lane SRAM controller.
package sram_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    RSP_ZERO  = 2'd0,
    RSP_BANK  = 2'd1,
    RSP_MERGE = 2'd2
  } rsp_sel_e;

  function automatic int unsigned nb(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned off_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word lane that carries request lane `lane` for an access starting at byte offset `off`.
  function automatic int unsigned rot_lane(input int unsigned lane, input int unsigned off,
                                           input int unsigned nbytes);
    return (lane + off) % nbytes;
  endfunction

  // Request lane falls in the first word of the access (beat 1) rather than the next word.
  function automatic logic in_beat1(input int unsigned lane, input int unsigned off,
                                    input int unsigned nbytes);
    return (lane + off) < nbytes;
  endfunction

endpackage

// File: rtl/sram_word_bank.sv
// Single-port word array with per-byte write enables and a registered read.
module sram_word_bank
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 16384
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              en,
  input  logic                                              we,
  input  logic [((DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1)-1:0] idx,
  input  logic [DATA_W/8-1:0]                               be,
  input  logic [DATA_W-1:0]                                 wdata,
  output logic [DATA_W-1:0]                                 rdata
);

  localparam int unsigned NB = nb(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read data only moves on a read beat so it can be merged a cycle later.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem_q[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_bytelane_ctrl.sv
// Byte-addressable SRAM controller with valid/ready requests and registered reads.
// Define SRAM_MISALIGN_EN to split misaligned accesses into two beats; otherwise they error.
module sram_bytelane_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH_WORDS = 2 ** (ADDR_W - $clog2(DATA_W / 8))
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned NB     = nb(DATA_W);
  localparam int unsigned OFF_W  = off_w(DATA_W);
  localparam int unsigned WORD_W = ADDR_W - OFF_W;
  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [OFF_W-1:0]  off;
  logic [WORD_W-1:0] word;
  logic              misalign;
  logic              accept;

  logic              bank_en;
  logic              bank_we;
  logic [IDX_W-1:0]  bank_idx;
  logic [NB-1:0]     bank_be;
  logic [DATA_W-1:0] bank_wdata;
  logic [DATA_W-1:0] bank_rdata;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  rsp_sel_e          rsp_sel_q, rsp_sel_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] rsp_live;

`ifdef SRAM_MISALIGN_EN
  state_e            state_q, state_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              we_q, we_d;
  logic [NB-1:0]     wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [IDX_W-1:0]  idx2_q, idx2_d;
  logic [DATA_W-1:0] part_q, part_d;
`endif

  function automatic logic [IDX_W-1:0] idx_of(input logic [WORD_W-1:0] w);
    return IDX_W'(32'(w) % DEPTH_WORDS);
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (32'(i) == DEPTH_WORDS - 1) return '0;
    return i + IDX_W'(1);
  endfunction

  // Place strobes of the request lanes that belong to the given beat onto word lanes.
  function automatic logic [NB-1:0] beat_be(input logic [NB-1:0] strb,
                                            input logic [OFF_W-1:0] o, input logic beat1);
    beat_be = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (in_beat1(i, 32'(o), NB) == beat1) beat_be[rot_lane(i, 32'(o), NB)] = strb[i];
    end
  endfunction

  function automatic logic [DATA_W-1:0] beat_data(input logic [DATA_W-1:0] data,
                                                  input logic [OFF_W-1:0] o, input logic beat1);
    beat_data = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (in_beat1(i, 32'(o), NB) == beat1)
        beat_data[8*rot_lane(i, 32'(o), NB) +: 8] = data[8*i +: 8];
    end
  endfunction

`ifdef SRAM_MISALIGN_EN
  // Rebuild request lanes from the beat-1 word (part) and the beat-2 word (cur).
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] part,
                                                    input logic [DATA_W-1:0] cur,
                                                    input logic [OFF_W-1:0] o);
    merge_lanes = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (in_beat1(i, 32'(o), NB))
        merge_lanes[8*i +: 8] = part[8*rot_lane(i, 32'(o), NB) +: 8];
      else
        merge_lanes[8*i +: 8] = cur[8*rot_lane(i, 32'(o), NB) +: 8];
    end
  endfunction
`endif

  assign off      = req_addr[OFF_W-1:0];
  assign word     = req_addr[ADDR_W-1:OFF_W];
  assign misalign = (off != '0);
  assign accept   = req_valid && req_ready;

`ifdef SRAM_MISALIGN_EN
  assign req_ready = !rst && (state_q == IDLE);
`else
  assign req_ready = !rst;
`endif

  // Beat sequencing, bank port steering and response capture.
  always_comb begin
    bank_en     = 1'b0;
    bank_we     = 1'b0;
    bank_idx    = idx_of(word);
    bank_be     = '0;
    bank_wdata  = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_sel_d   = rsp_sel_q;
`ifdef SRAM_MISALIGN_EN
    state_d     = state_q;
    off_d       = off_q;
    we_d        = we_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    idx2_d      = idx2_q;
    part_d      = part_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          bank_en    = 1'b1;
          bank_we    = req_we;
          bank_be    = beat_be(req_wstrb, off, 1'b1);
          bank_wdata = beat_data(req_wdata, off, 1'b1);
          if (misalign) begin
            state_d = SECOND;
            off_d   = off;
            we_d    = req_we;
            wstrb_d = req_wstrb;
            wdata_d = req_wdata;
            idx2_d  = next_idx(idx_of(word));
          end else begin
            rsp_valid_d = 1'b1;
            rsp_sel_d   = req_we ? RSP_ZERO : RSP_BANK;
          end
        end
      end
      SECOND: begin
        bank_en     = !rst;
        bank_we     = we_q;
        bank_idx    = idx2_q;
        bank_be     = beat_be(wstrb_q, off_q, 1'b0);
        bank_wdata  = beat_data(wdata_q, off_q, 1'b0);
        part_d      = bank_rdata;
        rsp_valid_d = 1'b1;
        rsp_sel_d   = we_q ? RSP_ZERO : RSP_MERGE;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
`else
    if (accept) begin
      rsp_valid_d = 1'b1;
      if (misalign) begin
        rsp_err_d = 1'b1;
        rsp_sel_d = RSP_ZERO;
      end else begin
        bank_en    = 1'b1;
        bank_we    = req_we;
        bank_be    = beat_be(req_wstrb, off, 1'b1);
        bank_wdata = beat_data(req_wdata, off, 1'b1);
        rsp_sel_d  = req_we ? RSP_ZERO : RSP_BANK;
      end
    end
`endif
    hold_d = rsp_rdata;
  end

  // Response data is selected from registered sources only.
  always_comb begin
    rsp_live = '0;
    case (rsp_sel_q)
      RSP_BANK:  rsp_live = bank_rdata;
`ifdef SRAM_MISALIGN_EN
      RSP_MERGE: rsp_live = merge_lanes(part_q, bank_rdata, off_q);
`endif
      default:   rsp_live = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_sel_q   <= RSP_ZERO;
      hold_q      <= '0;
`ifdef SRAM_MISALIGN_EN
      state_q     <= IDLE;
      off_q       <= '0;
      we_q        <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      idx2_q      <= '0;
      part_q      <= '0;
`endif
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_sel_q   <= rsp_sel_d;
      hold_q      <= hold_d;
`ifdef SRAM_MISALIGN_EN
      state_q     <= state_d;
      off_q       <= off_d;
      we_q        <= we_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      idx2_q      <= idx2_d;
      part_q      <= part_d;
`endif
    end
  end

  // Between responses the last delivered value is held.
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_valid_q ? rsp_live : hold_q;

  sram_word_bank #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .en    (bank_en),
    .we    (bank_we),
    .idx   (bank_idx),
    .be    (bank_be),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

endmodule
